// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: execute-stage controller for the 16-bit ALU.
// Ports: clk/rst_n (async active-low); start/ready handshake; flush aborts to IDLE;
// encoded_opcode, rs1data, rs2data, statusregin are latched at acceptance;
// alu_result/alu_status come from the combinational ALU; result_lo/result_hi,
// result_valid, reg_we, reg_we2, statusregout, status_we feed writeback.
module alu_exec_sequencer #(
   parameter int         DATA_W = 16,
   parameter logic [5:0] MUL_OP = 6'b100001,
   parameter logic [5:0] MLS_OP = 6'b100010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              ready,
   input  logic              flush,
   input  logic [5:0]        encoded_opcode,
   input  logic [DATA_W-1:0] rs1data,
   input  logic [DATA_W-1:0] rs2data,
   input  logic [7:0]        statusregin,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [7:0]        alu_status,
   output logic [DATA_W-1:0] result_lo,
   output logic [DATA_W-1:0] result_hi,
   output logic              result_valid,
   output logic              reg_we,
   output logic              reg_we2,
   output logic [7:0]        statusregout,
   output logic              status_we
);
   localparam logic [1:0] IDLE = 2'd0, SINGLE = 2'd1, MUL_ITER = 2'd2, FINISH = 2'd3;
   logic [1:0]          state;
   logic [3:0]          cnt;
   logic [5:0]          op;
   logic [5:0]          sr_keep;
   logic                neg;
   logic [DATA_W-1:0]   mcand;
   logic [2*DATA_W-1:0] acc;
   logic                in_mul, in_mls, we_ok, st_alu;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W:0]     sum;
   logic [2*DATA_W-1:0] acc_nxt, prod;
   assign ready = state == IDLE;
   always_comb begin
      in_mls  = encoded_opcode == MLS_OP;
      in_mul  = encoded_opcode == MUL_OP || in_mls;
      // 0x8000 negates to itself, which is the correct unsigned magnitude
      a_mag   = (in_mls && rs1data[DATA_W-1]) ? -rs1data : rs1data;
      b_mag   = (in_mls && rs2data[DATA_W-1]) ? -rs2data : rs2data;
      // acc holds {partial product, remaining multiplier bits}
      sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, acc[0] ? mcand : {DATA_W{1'b0}}};
      acc_nxt = {sum, acc[DATA_W-1:1]};
      prod    = neg ? -acc : acc;
      we_ok   = !(op == 6'h20 || (op >= 6'h29 && op <= 6'h38));
      st_alu  = (op >= 6'h06 && op <= 6'h09) || (op >= 6'h11 && op <= 6'h16) || (op >= 6'h1D && op <= 6'h20);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         op           <= '0;
         sr_keep      <= '0;
         neg          <= 1'b0;
         mcand        <= '0;
         acc          <= '0;
         result_lo    <= '0;
         result_hi    <= '0;
         result_valid <= 1'b0;
         reg_we       <= 1'b0;
         reg_we2      <= 1'b0;
         statusregout <= '0;
         status_we    <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         reg_we       <= 1'b0;
         reg_we2      <= 1'b0;
         status_we    <= 1'b0;
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  op      <= encoded_opcode;
                  sr_keep <= statusregin[7:2];
                  neg     <= in_mls && (rs1data[DATA_W-1] ^ rs2data[DATA_W-1]);
                  mcand   <= a_mag;
                  acc     <= {{DATA_W{1'b0}}, b_mag};
                  cnt     <= '0;
                  state   <= in_mul ? MUL_ITER : SINGLE;
               end
               SINGLE: begin
                  result_lo    <= alu_result;
                  result_hi    <= '0;
                  result_valid <= 1'b1;
                  reg_we       <= we_ok;
                  status_we    <= st_alu;
                  statusregout <= st_alu ? alu_status : statusregout;
                  state        <= IDLE;
               end
               MUL_ITER: begin
                  acc   <= acc_nxt;
                  cnt   <= cnt + 4'd1;
                  state <= (cnt == 4'd15) ? FINISH : MUL_ITER;
               end
               default: begin
                  result_hi    <= prod[2*DATA_W-1:DATA_W];
                  result_lo    <= prod[DATA_W-1:0];
                  result_valid <= 1'b1;
                  reg_we       <= 1'b1;
                  reg_we2      <= 1'b1;
                  status_we    <= 1'b1;
                  statusregout <= {sr_keep, prod[2*DATA_W-1], prod == '0};
                  state        <= IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer: directed self-checking bench for alu_exec_sequencer.
module tb_alu_exec_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
   logic [5:0]  encoded_opcode = '0;
   logic [15:0] rs1data = '0, rs2data = '0, alu_result = '0;
   logic [7:0]  statusregin = '0, alu_status = '0;
   logic        ready, result_valid, reg_we, reg_we2, status_we;
   logic [15:0] result_lo, result_hi;
   logic [7:0]  statusregout;
   int checks = 0, failures = 0, lat, pulses, pulse_at;

   alu_exec_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .flush(flush),
      .encoded_opcode(encoded_opcode), .rs1data(rs1data), .rs2data(rs2data),
      .statusregin(statusregin), .alu_result(alu_result), .alu_status(alu_status),
      .result_lo(result_lo), .result_hi(result_hi), .result_valid(result_valid),
      .reg_we(reg_we), .reg_we2(reg_we2), .statusregout(statusregout), .status_we(status_we)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request for an edge, scramble the inputs afterwards so latching
   // is exercised, then wait (bounded) for result_valid; lat counts edges after E0.
   task automatic issue(input logic [5:0] o, input logic [15:0] a, input logic [15:0] b, input logic [7:0] sr);
      encoded_opcode = o; rs1data = a; rs2data = b; statusregin = sr; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rs1data = ~a; rs2data = ~b; statusregin = ~sr; encoded_opcode = 6'h3F;
      lat = 0;
      while (!result_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic mul_chk(input string tag, input logic [5:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] sr, input logic [31:0] p, input logic [7:0] sro);
      issue(o, a, b, sr);
      chk({tag, "_lat"}, lat, 17);
      chk({tag, "_prod"}, {result_hi, result_lo}, p);
      chk({tag, "_sro"}, statusregout, sro);
      chk({tag, "_we"}, {reg_we, reg_we2, status_we, ready}, 4'b1111);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1; flush = 1'b0; encoded_opcode = 6'h21;
      rs1data = 16'($urandom); rs2data = 16'($urandom); statusregin = 8'($urandom);
      alu_result = 16'($urandom); alu_status = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_strobes", {result_valid, reg_we, reg_we2, status_we}, 0);
      chk("rst_data", {result_hi, result_lo}, 0);
      chk("rst_sro", statusregout, 0);
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      // ADD then back-to-back COMP started in the result_valid cycle
      alu_result = 16'h0003; alu_status = 8'h00;
      issue(6'h11, 16'h0001, 16'h0002, 8'h00);
      chk("add_lat", lat, 1);
      chk("add_res", {result_hi, result_lo}, 32'h0000_0003);
      chk("add_we", {reg_we, reg_we2, status_we, ready}, 4'b1011);
      alu_result = 16'h0055; alu_status = 8'h0A;
      issue(6'h20, 16'h0, 16'h0, 8'h00);
      chk("comp_lat", lat, 1);
      chk("comp_res", result_lo, 16'h0055);
      chk("comp_we", {reg_we, reg_we2, status_we}, 3'b001);
      chk("comp_sro", statusregout, 8'h0A);
      @(posedge clk); #1;
      chk("pulse_once", result_valid, 0);
      alu_result = 16'h1111; alu_status = 8'hFF;
      issue(6'h01, 16'h0, 16'h0, 8'h00);
      chk("op01_we", {reg_we, status_we}, 2'b10);
      chk("op01_sro_hold", statusregout, 8'h0A);
      alu_result = 16'h2222;
      issue(6'h30, 16'h0, 16'h0, 8'h00);
      chk("flag_we", {reg_we, status_we, result_lo}, {2'b00, 16'h2222});
      // Multiplies
      mul_chk("mul_ff", 6'h21, 16'hFFFF, 16'hFFFF, 8'hA4, 32'hFFFE_0001, 8'hA6);
      mul_chk("mls_8k_m1", 6'h22, 16'h8000, 16'hFFFF, 8'h00, 32'h0000_8000, 8'h00);
      mul_chk("mls_8k_8k", 6'h22, 16'h8000, 16'h8000, 8'hFC, 32'h4000_0000, 8'hFC);
      mul_chk("mls_3_m2", 6'h22, 16'h0003, 16'hFFFE, 8'h03, 32'hFFFF_FFFA, 8'h02);
      // MUL by zero with start pulses during the busy window
      encoded_opcode = 6'h21; rs1data = 16'h1234; rs2data = 16'h0000; statusregin = 8'h02; start = 1'b1;
      @(posedge clk); #1;
      pulses = 0; pulse_at = 0;
      for (int i = 1; i <= 17; i++) begin
         start = i[0]; encoded_opcode = 6'h11;
         @(posedge clk); #1;
         if (result_valid) begin pulses++; pulse_at = i; end
      end
      start = 1'b0;
      chk("mul0_prod", {result_hi, result_lo}, 32'h0);
      chk("mul0_sro", statusregout, 8'h01);
      chk("mul0_at", pulse_at, 17);
      repeat (3) begin
         @(posedge clk); #1;
         if (result_valid) pulses++;
      end
      chk("busy_ignored", pulses, 1);
      chk("busy_ready", ready, 1);
      // flush at iteration 8
      encoded_opcode = 6'h21; rs1data = 16'h0005; rs2data = 16'h0007; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("busy_mid", ready, 0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready", ready, 1);
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (result_valid) pulses++;
      end
      chk("flush_no_valid", pulses, 0);
      chk("flush_keep", {result_hi, result_lo}, 32'h0);
      // flush wins over start
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_prio", ready, 1);
      // async reset at iteration 5
      encoded_opcode = 6'h21; rs1data = 16'h0009; rs2data = 16'h0009; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", ready, 1);
      chk("arst_sro", statusregout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (result_valid) pulses++;
      end
      chk("arst_no_valid", pulses, 0);
      mul_chk("mul_2x3", 6'h21, 16'h0002, 16'h0003, 8'h00, 32'h0000_0006, 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
Execute-stage controller for the 16-bit ALU. It accepts one decoded operation per start handshake and classifies it by its 6-bit encoded opcode. Single-cycle ops are captured from the combinational ALU outputs. MUL (unsigned) and MLS (signed) run an iterative 16-step shift-add in the sequencer. It produces registered results, register-file write enables and status-register updates for the writeback logic.

Parameters:
DATA_W, 16, operand width; multiply result is 2*DATA_W.
MUL_OP, 6'b100001, encoded opcode for unsigned multiply.
MLS_OP, 6'b100010, encoded opcode for signed multiply.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  operation request; accepted only when ready=1.
ready  output  1  1 when the sequencer is IDLE.
flush  input  1  synchronous abort; returns the sequencer to IDLE.
encoded_opcode  input  6  decoded opcode, sampled at acceptance.
rs1data  input  16  operand A, sampled at acceptance.
rs2data  input  16  operand B, sampled at acceptance.
statusregin  input  8  current status register.
alu_result  input  16  combinational ALU aluout1 for the current opcode.
alu_status  input  8  combinational ALU status output.
result_lo  output  16  result, or product bits [15:0].
result_hi  output  16  product bits [31:16]; 0 for non-multiply ops.
result_valid  output  1  one-cycle pulse: results are valid.
reg_we  output  1  write result_lo to Rd; qualified by result_valid.
reg_we2  output  1  write result_hi to the second destination; multiply only.
statusregout  output  8  status value to write.
status_we  output  1  status register write strobe, one cycle.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ready=1, all other outputs 0, internal accumulator/counter cleared. Reset during a multiply discards it; no result_valid follows.
- States: IDLE, SINGLE, MUL_ITER, FINISH.
- Acceptance edge E0 requires start&&ready&&!flush. At E0 the opcode, operands and statusregin are latched.
  - MUL_OP or MLS_OP: go to MUL_ITER.
  - Any other opcode: go to SINGLE.
- start while ready=0 is ignored and not queued.
- SINGLE: at E1, capture alu_result and alu_status.
  - result_lo=alu_result, result_hi=0.
  - result_valid=1 for the cycle after E1; return to IDLE at E1.
  - Single-cycle latency; ready=1 again in the same cycle as result_valid, so back-to-back starts are legal.
  - alu_result/alu_status must be stable from E0 to E1, which the decode stage guarantees.
- MUL_ITER: 4-bit counter from 0 to 15, one iteration per edge E1..E16.
  - Iteration: if multiplier LSB is 1, add the multiplicand into the upper half with carry; shift {carry, acc} right by 1.
  - MLS: operands are converted to magnitudes at E0 (0x8000 magnitude = 0x8000, unsigned 17-bit safe); negation flag = signA^signB.
  - After E16 go to FINISH. At E17 write result_{hi,lo}; MLS result is two's-complement negated if the flag is set. Pulse result_valid, return to IDLE.
  - Total latency 17 cycles; ready=0 from E0 through E17.
- reg_we:
  - 1 with result_valid for all ops except COMP (6'h20) and flag/branch ops (6'h29..6'h38).
  - reg_we2=1 only for MUL/MLS.
- status_we pulses with result_valid when:
  - opcode is 6'h06..6'h09, 6'h11..6'h16 or 6'h1D..6'h20: statusregout=alu_status.
  - opcode is MUL/MLS: statusregout=statusregin with Z (bit0) = (product==0) and N (bit1) = product[31]; C (bit2) and bits[7:3] unchanged.
  - Otherwise status_we=0 and statusregout holds its last value.
- flush=1 at any edge: state=IDLE, counter=0, no result_valid, no write strobes. flush has priority over start in the same cycle. Output data registers keep their last values.
- All outputs are registered; there are no combinational paths from inputs to outputs except ready, which is derived from state only.

Test Plan:
- Reset: hold rst_n=0 with random inputs → ready=1, result_valid=0, reg_we=0, status_we=0, result_hi=result_lo=0.
- ADD, opcode 6'h11, alu_result=0x0003, alu_status=0x00 → result_valid at E1; result_lo=0x0003, result_hi=0, reg_we=1, status_we=1. Second start in that same cycle is accepted.
- MUL, 0xFFFF×0xFFFF → result_valid exactly 17 cycles after accept; hi=0xFFFE, lo=0x0001, reg_we2=1, Z=0, N=1, C equal to the latched statusregin[2].
- MLS, 0x8000×0xFFFF → hi=0x0000, lo=0x8000. MLS 0x8000×0x8000 → hi=0x4000, lo=0x0000. MLS 0x0003×0xFFFE → hi=0xFFFF, lo=0xFFFA.
- MUL 0x1234×0 → product 0, Z=1, N=0. Start pulses during the 17 busy cycles are ignored, with no extra result_valid.
- Abort: flush at iteration 8 → ready=1 next cycle, no result_valid. Separately, rst_n low at iteration 5 → immediate IDLE; a subsequent MUL 2×3 yields hi=0, lo=6.
